instr_mem_responder: RTL and testbench

- Responder (slave) end of the core's instruction-memory req/gnt/rvalid protocol. It is the counterpart of the fetch-side tracing and monitoring logic.
- Holds a word-addressed program memory with a separate load port for preloading programs.
- Grants fetch requests with a configurable grant delay, an external stall and an outstanding-request limit.
- Returns instruction data with rvalid a fixed number of cycles after each grant, pipelined, so the trace units can be exercised against realistic memory timing.

---
 rtl/instr_mem_responder_if.sv | 30 +++
 rtl/instr_mem_responder.sv | 124 ++++++++++++
 tb/tb_instr_mem_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// Instruction-memory fetch bus (req/gnt/rvalid) plus the program-load port
// and the outstanding-request count seen by the responder.
interface instr_mem_if #(
  parameter int INSTR_ADDR_WIDTH = 16,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING  = 2
);
  localparam int OUTSTANDING_W = $clog2(MAX_OUTSTANDING + 1);

  logic                        instr_req;
  logic [INSTR_ADDR_WIDTH-1:0] instr_addr;
  logic                        instr_gnt;
  logic                        instr_rvalid;
  logic [INSTR_DATA_WIDTH-1:0] instr_rdata;
  logic                        grant_stall;
  logic                        load_we;
  logic [INSTR_ADDR_WIDTH-1:0] load_addr;
  logic [INSTR_DATA_WIDTH-1:0] load_data;
  logic [OUTSTANDING_W-1:0]    outstanding;

  modport slave (
    input  instr_req, instr_addr, grant_stall, load_we, load_addr, load_data,
    output instr_gnt, instr_rvalid, instr_rdata, outstanding
  );

  modport master (
    output instr_req, instr_addr, grant_stall, load_we, load_addr, load_data,
    input  instr_gnt, instr_rvalid, instr_rdata, outstanding
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Responder end of the instruction fetch protocol: word-addressed program memory
// with delayed/stallable grants and a fixed-latency, in-order response pipeline.
module instr_mem_responder #(
  parameter int INSTR_ADDR_WIDTH = 16,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int MEM_DEPTH        = 1024,
  parameter int GNT_DELAY        = 0,
  parameter int RVALID_LATENCY   = 1,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  instr_mem_if.slave bus
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WAIT_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int LAT    = RVALID_LATENCY;

  logic [INSTR_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]            fetch_idx;
  logic [IDX_W-1:0]            load_idx;
  logic [INSTR_DATA_WIDTH-1:0] fetch_word;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic              delay_ok;
  logic              slot_free;
  logic              gnt;
  logic              rvalid;

  logic                        vld_p_q  [LAT];
  logic [INSTR_DATA_WIDTH-1:0] data_p_q [LAT];

  logic unused_addr_bits;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_W'(GNT_DELAY)) ? v : v + 1'b1;
  endfunction

  // Byte address -> word index; bits above the index wrap modulo MEM_DEPTH.
  if (INSTR_ADDR_WIDTH - 2 >= IDX_W) begin : g_idx_slice
    assign fetch_idx = bus.instr_addr[IDX_W+1:2];
    assign load_idx  = bus.load_addr[IDX_W+1:2];
  end else begin : g_idx_ext
    assign fetch_idx = IDX_W'(bus.instr_addr[INSTR_ADDR_WIDTH-1:2]);
    assign load_idx  = IDX_W'(bus.load_addr[INSTR_ADDR_WIDTH-1:2]);
  end
  assign unused_addr_bits = ^{bus.instr_addr, bus.load_addr};

  if (GNT_DELAY == 0) begin : g_no_delay
    assign delay_ok = 1'b1;
  end else begin : g_delay
    assign delay_ok = (wait_q >= WAIT_W'(GNT_DELAY));
  end

  // Registered count only: a same-cycle rvalid frees its slot next cycle.
  assign slot_free = (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign gnt       = rst_n && bus.instr_req && !bus.grant_stall && delay_ok && slot_free;
  assign rvalid    = vld_p_q[LAT-1];

  assign fetch_word = mem_q[fetch_idx];

  always_comb begin
    wait_d  = '0;
    outst_d = outst_q;
    if (bus.instr_req && !gnt) wait_d = sat_inc(wait_q);
    if (gnt && !rvalid)        outst_d = outst_q + 1'b1;
    else if (!gnt && rvalid)   outst_d = outst_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q  <= '0;
      outst_q <= '0;
    end else begin
      wait_q  <= wait_d;
      outst_q <= outst_d;
    end
  end

  // Load port is independent of reset and fetch; the fetch read above sees the old word.
  always_ff @(posedge clk) begin
    if (bus.load_we) mem_q[load_idx] <= bus.load_data;
  end

  // Stage 0 captures on the grant cycle; the last stage is the rvalid/rdata register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) vld_p_q[s] <= 1'b0;
    end else begin
      vld_p_q[0] <= gnt;
      for (int s = 1; s < LAT; s++) vld_p_q[s] <= vld_p_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) data_p_q[0] <= fetch_word;
    for (int s = 1; s < LAT; s++) begin
      if (vld_p_q[s-1]) data_p_q[s] <= data_p_q[s-1];
    end
    if (!rst_n) data_p_q[LAT-1] <= '0;
  end

  assign bus.instr_gnt    = gnt;
  assign bus.instr_rvalid = rvalid;
  assign bus.instr_rdata  = data_p_q[LAT-1];
  assign bus.outstanding  = outst_q;

`ifndef SYNTHESIS
  if (RVALID_LATENCY < 1) begin : g_chk_lat
    $error("instr_mem_responder: RVALID_LATENCY must be >= 1");
  end
  if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("instr_mem_responder: MEM_DEPTH must be a power of two");
  end

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) bus.instr_rvalid |-> (bus.outstanding != '0)
  );
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Drives three responder configurations with shared stimulus and checks each
// against a queue-based reference of the fetch protocol every cycle.
module tb_instr_mem_responder;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req;
  logic [AW-1:0] addr;
  logic          stall;
  logic          lwe;
  logic [AW-1:0] laddr;
  logic [DW-1:0] ldata;

  int checks = 0;
  int errors = 0;

  logic          gnt_w [NI];
  logic          rv_w  [NI];
  logic [DW-1:0] rd_w  [NI];
  logic [1:0]    os_w  [NI];

  task automatic check(input string nm, input int inst, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  // Instance 0: defaults. Instance 1: GNT_DELAY=2. Instance 2: RVALID_LATENCY=3.
  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int G = (gi == 1) ? 2 : 0;
    localparam int L = (gi == 2) ? 3 : 1;
    localparam int M = 2;

    instr_mem_if #(.INSTR_ADDR_WIDTH(AW), .INSTR_DATA_WIDTH(DW), .MAX_OUTSTANDING(M)) bus ();

    instr_mem_responder #(
      .INSTR_ADDR_WIDTH(AW), .INSTR_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
      .GNT_DELAY(G), .RVALID_LATENCY(L), .MAX_OUTSTANDING(M)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.instr_req   = req;
    assign bus.instr_addr  = addr;
    assign bus.grant_stall = stall;
    assign bus.load_we     = lwe;
    assign bus.load_addr   = laddr;
    assign bus.load_data   = ldata;

    assign gnt_w[gi] = bus.instr_gnt;
    assign rv_w[gi]  = bus.instr_rvalid;
    assign rd_w[gi]  = bus.instr_rdata;
    assign os_w[gi]  = bus.outstanding;

    // Reference: memory image, and a FIFO of (due cycle, word) per granted fetch.
    logic [DW-1:0] mem_m [DEPTH];
    int            due_q [$];
    logic [DW-1:0] dat_q [$];
    int            wait_c = 0;
    int            cyc    = 0;
    bit            armed  = 1'b0;
    bit            e_rv   = 1'b0;
    logic [DW-1:0] e_rd   = '0;
    bit            e_gnt;

    always @(negedge clk) begin
      e_gnt = req && !stall && (wait_c >= G) && (due_q.size() < M);
      if (armed) begin
        check("gnt",         gi, DW'(bus.instr_gnt),    DW'(e_gnt));
        check("rvalid",      gi, DW'(bus.instr_rvalid), DW'(e_rv));
        check("rdata",       gi, bus.instr_rdata,       e_rd);
        check("outstanding", gi, DW'(bus.outstanding),  DW'(due_q.size()));
      end
      if (!rst_n) begin
        due_q.delete();
        dat_q.delete();
        wait_c = 0;
        e_rv   = 1'b0;
        e_rd   = '0;
        armed  = 1'b1;
      end else begin
        if (e_rv) begin
          void'(due_q.pop_front());
          void'(dat_q.pop_front());
        end
        if (e_gnt) begin
          due_q.push_back(cyc + L);
          dat_q.push_back(mem_m[(int'(addr) >> 2) % DEPTH]);
          wait_c = 0;
        end else if (req) begin
          wait_c = (wait_c < G) ? wait_c + 1 : wait_c;
        end else begin
          wait_c = 0;
        end
        e_rv = (due_q.size() > 0) && (due_q[0] == cyc + 1);
        if (e_rv) e_rd = dat_q[0];
      end
      if (lwe) mem_m[(int'(laddr) >> 2) % DEPTH] = ldata;
      cyc++;
    end
  end

  task automatic drive(input bit r, input logic [AW-1:0] a, input bit s, input bit w,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld);
    @(posedge clk);
    #1;
    req   = r;
    addr  = a;
    stall = s;
    lwe   = w;
    laddr = la;
    ldata = ld;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  bit            r_r, r_s, r_w, r_rst;
  logic [AW-1:0] r_a, r_la;
  logic [DW-1:0] r_ld;

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    addr  = '0;
    stall = 1'b0;
    lwe   = 1'b0;
    laddr = '0;
    ldata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b0, 1'b1, AW'(i * 4), $urandom);
    drive(1'b0, '0, 1'b0, 1'b1, 16'h0000, 32'h0000_0013);
    drive(1'b0, '0, 1'b0, 1'b1, 16'h0004, 32'h00A1_2083);
    drive(1'b0, '0, 1'b0, 1'b1, 16'h0014, 32'hAAAA_0000);
    idle(6);

    // Back-to-back fetches with default timing.
    drive(1'b1, 16'h0000, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("s1_gnt_c0", 0, DW'(gnt_w[0]), 1);
    check("s1_os_c0",  0, DW'(os_w[0]),  0);
    check("s1_nogntd", 1, DW'(gnt_w[1]), 0);
    drive(1'b1, 16'h0004, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("s1_gnt_c1", 0, DW'(gnt_w[0]), 1);
    check("s1_rv_c1",  0, DW'(rv_w[0]),  1);
    check("s1_rd_c1",  0, rd_w[0],       32'h0000_0013);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("s1_rv_c2",  0, DW'(rv_w[0]),  1);
    check("s1_rd_c2",  0, rd_w[0],       32'h00A1_2083);
    idle(6);

    // Grant delay of two cycles, then req dropped and reasserted.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0008, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("s2_gnt", 1, DW'(gnt_w[1]), DW'(k == 2));
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("s2_rv_c3", 1, DW'(rv_w[1]), 1);
    idle(6);
    drive(1'b1, 16'h0008, 1'b0, 1'b0, '0, '0);
    idle(2);
    for (int k = 3; k < 6; k++) begin
      drive(1'b1, 16'h0008, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("s2_regnt", 1, DW'(gnt_w[1]), DW'(k == 5));
    end
    idle(6);

    // Latency 3 against an outstanding limit of 2.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h000C, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("s3_gnt", 2, DW'(gnt_w[2]), DW'(k < 2 || k == 4));
      check("s3_rv",  2, DW'(rv_w[2]),  DW'(k == 3 || k == 4));
      check("s3_os",  2, DW'(os_w[2]),  (k == 0) ? 0 : (k == 1 || k == 4) ? 1 : 2);
    end
    idle(8);

    // External stall holds off the grant.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 16'h0010, (k < 5), 1'b0, '0, '0);
      @(negedge clk);
      check("s4_gnt", 0, DW'(gnt_w[0]), DW'(k == 5));
      check("s4_os",  0, DW'(os_w[0]),  0);
    end
    idle(6);

    // Load and fetch of the same word in one cycle, then the wrapped alias.
    drive(1'b1, 16'h0014, 1'b0, 1'b1, 16'h0014, 32'h5555_FFFF);
    @(negedge clk);
    check("s5_gnt", 0, DW'(gnt_w[0]), 1);
    drive(1'b1, 16'h1014, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("s5_rv_old", 0, DW'(rv_w[0]), 1);
    check("s5_rd_old", 0, rd_w[0],      32'hAAAA_0000);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("s5_rd_new", 0, rd_w[0],      32'h5555_FFFF);
    idle(6);

    // Reset while a latency-3 response is in flight.
    drive(1'b1, 16'h0014, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("s6_gnt", 2, DW'(gnt_w[2]), 1);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s6_rd_rst", 2, rd_w[2], 0);
    for (int k = 2; k < 5; k++) begin
      if (k > 2) drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("s6_no_rv", 2, DW'(rv_w[2]), 0);
      check("s6_os",    2, DW'(os_w[2]), 0);
    end
    drive(1'b1, 16'h0014, 1'b0, 1'b0, '0, '0);
    idle(3);
    @(negedge clk);
    check("s6_rv_after", 2, DW'(rv_w[2]), 1);
    check("s6_mem_kept", 2, rd_w[2],      32'h5555_FFFF);
    idle(6);

    // Random traffic with occasional resets and forced load/fetch collisions.
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_r   = ($urandom_range(0, 99) < 85) && !r_rst;
      r_s   = ($urandom_range(0, 99) < 15);
      r_w   = ($urandom_range(0, 99) < 20) && !r_rst;
      r_a   = AW'($urandom);
      r_la  = ($urandom_range(0, 3) == 0) ? r_a : AW'($urandom);
      r_ld  = $urandom;
      drive(r_r, r_a, r_s, r_w, r_la, r_ld);
      rst_n = !r_rst;
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
